// File: rtl/user_domain_sequencer.sv
// Power-up sequencer and Wishbone guard for the user-project boundary.
// Define USER_WB_TIMEOUT_EN to build the ACTIVE-state Wishbone timeout watchdog.
module user_domain_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES   = 16,
  parameter int unsigned RESET_HOLD_CYCLES = 8,
  parameter int unsigned WB_TIMEOUT        = 255
) (
  input  logic        caravel_clk,
  input  logic        caravel_rstn,
  input  logic        user1_vcc_powergood,
  input  logic        user2_vcc_powergood,
  input  logic        user1_vdd_powergood,
  input  logic        user2_vdd_powergood,
  input  logic        mprj_cyc_o_core,
  input  logic        mprj_stb_o_core,
  input  logic        mprj_ack_i_user,
  input  logic [31:0] mprj_dat_i_user,
  output logic        mprj_ack_i_core,
  output logic [31:0] mprj_dat_i_core,
  output logic        wb_pass_en,
  output logic        la_pass_en,
  output logic        user_reset,
  output logic [2:0]  seq_state,
  output logic        timeout_flag,
  input  logic        timeout_clr
);

  localparam logic [2:0] S_OFF        = 3'd0;
  localparam logic [2:0] S_DEBOUNCE   = 3'd1;
  localparam logic [2:0] S_RESET_HOLD = 3'd2;
  localparam logic [2:0] S_ACTIVE     = 3'd3;
  localparam logic [2:0] S_FAULT      = 3'd4;

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned HOLD_W = $clog2(RESET_HOLD_CYCLES) + 1;
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

  logic              pg_all, pg_meta, pg_s;
  logic [2:0]        state_q, state_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              active;
  logic              ack_q;
  logic              to_ack_q;

  assign pg_all = user1_vcc_powergood & user2_vcc_powergood &
                  user1_vdd_powergood & user2_vdd_powergood;

  always_ff @(posedge caravel_clk or negedge caravel_rstn) begin
    if (!caravel_rstn) begin
      pg_meta <= 1'b0;
      pg_s    <= 1'b0;
    end else begin
      pg_meta <= pg_all;
      pg_s    <= pg_meta;
    end
  end

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    hold_d  = hold_q;
    case (state_q)
      S_OFF: begin
        deb_d  = '0;
        hold_d = '0;
        if (pg_s) state_d = S_DEBOUNCE;
      end
      S_DEBOUNCE: begin
        if (!pg_s) begin
          state_d = S_OFF;
        end else if (deb_q == DEB_LAST) begin
          state_d = S_RESET_HOLD;
          deb_d   = '0;
          hold_d  = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      S_RESET_HOLD: begin
        if (!pg_s)                  state_d = S_OFF;
        else if (hold_q == HOLD_LAST) state_d = S_ACTIVE;
        else                        hold_d  = hold_q + 1'b1;
      end
      S_ACTIVE: if (!pg_s)           state_d = S_FAULT;
      S_FAULT:  if (!mprj_cyc_o_core) state_d = S_OFF;
      default:                       state_d = S_OFF;
    endcase
  end

  // Control outputs are registered from the next state so they change with seq_state.
  always_ff @(posedge caravel_clk or negedge caravel_rstn) begin
    if (!caravel_rstn) begin
      state_q    <= S_OFF;
      deb_q      <= '0;
      hold_q     <= '0;
      user_reset <= 1'b1;
      la_pass_en <= 1'b0;
      wb_pass_en <= 1'b0;
    end else begin
      state_q    <= state_d;
      deb_q      <= deb_d;
      hold_q     <= hold_d;
      user_reset <= (state_d != S_ACTIVE);
      la_pass_en <= (state_d == S_RESET_HOLD) || (state_d == S_ACTIVE);
      wb_pass_en <= (state_d == S_ACTIVE);
    end
  end

  assign seq_state = state_q;
  assign active    = (state_q == S_ACTIVE);

  // A held strobe alternates ack/no-ack so each pulse completes exactly one cycle.
  always_ff @(posedge caravel_clk or negedge caravel_rstn) begin
    if (!caravel_rstn) ack_q <= 1'b0;
    else ack_q <= !active & mprj_cyc_o_core & mprj_stb_o_core & !ack_q & !to_ack_q;
  end

`ifdef USER_WB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(WB_TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WB_TIMEOUT - 1);

  logic [WD_W-1:0] wd_q;
  logic            wd_fire;

  // A user ack in the last counting cycle beats the watchdog.
  assign wd_fire = active & mprj_cyc_o_core & mprj_stb_o_core &
                   !mprj_ack_i_user & (wd_q == WD_LAST);

  always_ff @(posedge caravel_clk or negedge caravel_rstn) begin
    if (!caravel_rstn) begin
      wd_q         <= '0;
      to_ack_q     <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      to_ack_q <= wd_fire;
      if (!active || !(mprj_cyc_o_core && mprj_stb_o_core) || mprj_ack_i_core || wd_fire)
        wd_q <= '0;
      else
        wd_q <= wd_q + 1'b1;
      if (wd_fire)          timeout_flag <= 1'b1;
      else if (timeout_clr) timeout_flag <= 1'b0;
    end
  end
`else
  localparam int unsigned unused_wb_timeout = WB_TIMEOUT;
  logic unused_timeout_clr;
  assign unused_timeout_clr = timeout_clr;
  assign to_ack_q     = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    mprj_ack_i_core = ack_q | to_ack_q;
    mprj_dat_i_core = '0;
    if (ack_q || to_ack_q) begin
      mprj_dat_i_core = '1;
    end else if (active) begin
      mprj_ack_i_core = mprj_ack_i_user;
      mprj_dat_i_core = mprj_dat_i_user;
    end
  end

endmodule

// File: tb/tb_user_domain_sequencer.sv
// Directed bench for user_domain_sequencer: table-driven power-up/pass-through plus corner sequences.
module tb_user_domain_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  pg;
  logic        cyc, stb, uack, tclr;
  logic [31:0] udat;
  logic        ack_core;
  logic [31:0] dat_core;
  logic        wb_en, la_en, ureset, tflag;
  logic [2:0]  st;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  user_domain_sequencer #(
    .DEBOUNCE_CYCLES(16),
    .RESET_HOLD_CYCLES(8),
    .WB_TIMEOUT(255)
  ) dut (
    .caravel_clk(clk),
    .caravel_rstn(rst_n),
    .user1_vcc_powergood(pg[0]),
    .user2_vcc_powergood(pg[1]),
    .user1_vdd_powergood(pg[2]),
    .user2_vdd_powergood(pg[3]),
    .mprj_cyc_o_core(cyc),
    .mprj_stb_o_core(stb),
    .mprj_ack_i_user(uack),
    .mprj_dat_i_user(udat),
    .mprj_ack_i_core(ack_core),
    .mprj_dat_i_core(dat_core),
    .wb_pass_en(wb_en),
    .la_pass_en(la_en),
    .user_reset(ureset),
    .seq_state(st),
    .timeout_flag(tflag),
    .timeout_clr(tclr)
  );

  typedef struct {
    int unsigned adv;
    logic [3:0]  pg;
    logic        cyc;
    logic        stb;
    logic        uack;
    logic [31:0] udat;
    logic [2:0]  st;
    logic        rst;
    logic        wb;
    logic        la;
    logic        ack;
    logic [31:0] dat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [2:0] e_st, input logic e_rst,
                         input logic e_wb, input logic e_la);
    chk({tag, " state"}, 32'(st), 32'(e_st));
    chk({tag, " user_reset"}, 32'(ureset), 32'(e_rst));
    chk({tag, " wb_pass_en"}, 32'(wb_en), 32'(e_wb));
    chk({tag, " la_pass_en"}, 32'(la_en), 32'(e_la));
  endtask

  initial begin
    rst_n = 1'b0; pg = 4'h0; cyc = 1'b0; stb = 1'b0; uack = 1'b0; udat = '0; tclr = 1'b0;

    // Reset values
    step(3);
    chk_ctl("reset", 3'd0, 1'b1, 1'b0, 1'b0);
    chk("reset ack", 32'(ack_core), 32'd0);
    chk("reset dat", dat_core, 32'd0);
    chk("reset flag", 32'(tflag), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Early access in OFF: held strobe acked every second cycle
    cyc = 1'b1; stb = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(1); #1;
      chk($sformatf("early ack %0d", i), 32'(ack_core), (i % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("early dat %0d", i), dat_core, (i % 2 == 1) ? 32'hFFFF_FFFF : 32'd0);
      chk($sformatf("early rst %0d", i), 32'(ureset), 32'd1);
    end
    cyc = 1'b0; stb = 1'b0;
    step(1); #1;
    chk("early idle ack", 32'(ack_core), 32'd0);

    // Power-up at defaults then ACTIVE pass-through, user ack in 4th cycle
    vecs[0] = '{2,  4'hF, 1'b0, 1'b0, 1'b0, 32'h0,         3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1,  4'hF, 1'b0, 1'b0, 1'b0, 32'h0,         3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{15, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0,         3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{1,  4'hF, 1'b0, 1'b0, 1'b0, 32'h0,         3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[4] = '{7,  4'hF, 1'b0, 1'b0, 1'b0, 32'h0,         3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[5] = '{1,  4'hF, 1'b0, 1'b0, 1'b0, 32'h0,         3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[6] = '{0,  4'hF, 1'b1, 1'b1, 1'b0, 32'h0,         3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[7] = '{3,  4'hF, 1'b1, 1'b1, 1'b0, 32'h0,         3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[8] = '{0,  4'hF, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1234_5678};
    vecs[9] = '{1,  4'hF, 1'b0, 1'b0, 1'b0, 32'h0,         3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    for (int i = 0; i < 10; i++) begin
      pg = vecs[i].pg; cyc = vecs[i].cyc; stb = vecs[i].stb;
      uack = vecs[i].uack; udat = vecs[i].udat;
      step(vecs[i].adv); #1;
      chk_ctl($sformatf("row%0d", i), vecs[i].st, vecs[i].rst, vecs[i].wb, vecs[i].la);
      chk($sformatf("row%0d ack", i), 32'(ack_core), 32'(vecs[i].ack));
      chk($sformatf("row%0d dat", i), dat_core, vecs[i].dat);
      chk($sformatf("row%0d flag", i), 32'(tflag), 32'd0);
    end

`ifdef USER_WB_TIMEOUT_EN
    // Watchdog: ack 255 cycles after stb first sampled
    cyc = 1'b1; stb = 1'b1;
    step(254); #1;
    chk("to pre ack", 32'(ack_core), 32'd0);
    chk("to pre flag", 32'(tflag), 32'd0);
    step(1); #1;
    chk("to ack", 32'(ack_core), 32'd1);
    chk("to dat", dat_core, 32'hFFFF_FFFF);
    chk("to flag set", 32'(tflag), 32'd1);
    cyc = 1'b0; stb = 1'b0;
    step(1); #1;
    chk("to ack single", 32'(ack_core), 32'd0);
    chk("to flag sticky", 32'(tflag), 32'd1);
    tclr = 1'b1;
    step(1); #1;
    tclr = 1'b0;
    chk("to flag clr", 32'(tflag), 32'd0);
    // User ack in the last counting cycle wins
    cyc = 1'b1; stb = 1'b1;
    step(254);
    uack = 1'b1; udat = 32'hA5A5_0F0F;
    #1;
    chk("race ack", 32'(ack_core), 32'd1);
    chk("race dat", dat_core, 32'hA5A5_0F0F);
    step(1);
    cyc = 1'b0; stb = 1'b0; uack = 1'b0; udat = '0;
    #1;
    chk("race no synth ack", 32'(ack_core), 32'd0);
    chk("race flag", 32'(tflag), 32'd0);
`else
    // No watchdog: an unanswered cycle waits for the user ack
    cyc = 1'b1; stb = 1'b1;
    step(300); #1;
    chk("nowd ack", 32'(ack_core), 32'd0);
    chk("nowd flag", 32'(tflag), 32'd0);
    uack = 1'b1; udat = 32'hA5A5_0F0F;
    #1;
    chk("nowd user ack", 32'(ack_core), 32'd1);
    chk("nowd user dat", dat_core, 32'hA5A5_0F0F);
    step(1);
    cyc = 1'b0; stb = 1'b0; uack = 1'b0; udat = '0;
    step(1); #1;
`endif

    // Power loss with a pending transaction
    cyc = 1'b1; stb = 1'b1;
    step(1); #1;
    chk("ploss pending ack", 32'(ack_core), 32'd0);
    pg = 4'hE;
    step(2); #1;
    chk("ploss +2 state", 32'(st), 32'd3);
    step(1); #1;
    chk_ctl("ploss +3", 3'd4, 1'b1, 1'b0, 1'b0);
    chk("ploss +3 ack", 32'(ack_core), 32'd0);
    step(1); #1;
    chk("ploss synth ack", 32'(ack_core), 32'd1);
    chk("ploss synth dat", dat_core, 32'hFFFF_FFFF);
    chk("ploss hold fault", 32'(st), 32'd4);
    cyc = 1'b0; stb = 1'b0;
    step(1); #1;
    chk("ploss off state", 32'(st), 32'd0);
    chk("ploss off ack", 32'(ack_core), 32'd0);
    chk("ploss off dat", dat_core, 32'd0);

    // Glitch mid-debounce restarts the sequence
    pg = 4'hF;
    step(3); #1;
    chk("glitch deb", 32'(st), 32'd1);
    step(5);
    pg = 4'h7;
    step(2); #1;
    chk("glitch still deb", 32'(st), 32'd1);
    step(1); #1;
    chk("glitch off", 32'(st), 32'd0);
    pg = 4'hF;
    step(2); #1;
    chk("glitch re off", 32'(st), 32'd0);
    step(1); #1;
    chk("glitch re deb", 32'(st), 32'd1);
    step(23); #1;
    chk("glitch hold", 32'(st), 32'd2);
    step(1); #1;
    chk_ctl("glitch active", 3'd3, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset mid-operation
    #3;
    rst_n = 1'b0;
    #1;
    chk_ctl("async rst", 3'd0, 1'b1, 1'b0, 1'b0);
    step(1);
    rst_n = 1'b1;
    step(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
